// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Streams a program file into target memory, then proves it landed intact.
//   The first FILE_OFFSET bytes of the file are discarded, the following bytes
//   (up to MEM_SIZE of them) are written one byte per transfer starting at
//   START_ADDR, and any excess bytes are drained. Each write is read back on
//   the second port one cycle later. After the file ends, the loaded region is
//   re-read and its byte sum is compared with the sum of the written bytes.
//   On success the memory is handed to the CPU.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   in_valid/in_byte/in_last/in_ready   byte stream with ready/valid handshake
//   mem_addr, mem_we, mem_write_size, mem_wd, mem_rd   main memory port
//   mem_ro_addr2, mem_rd2                 read-only port for write readback
//   loader_or_cpu     memory owner select (0 loader, 1 CPU)
//   done, error       terminal status
//   bytes_loaded      number of bytes written so far
//   err_addr          address of the first detected mismatch
// ---------------------------------------------------------------------------
module program_loader #(
   parameter int unsigned MEM_SIZE    = 8192,
   parameter logic [31:0] START_ADDR  = 32'h8000_0000,
   parameter logic [31:0] FILE_OFFSET = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   input  logic        in_last,
   output logic        in_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_ro_addr2,
   output logic        mem_we,
   output logic [1:0]  mem_write_size,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd,
   input  logic [31:0] mem_rd2,
   output logic        loader_or_cpu,
   output logic        done,
   output logic        error,
   output logic [31:0] bytes_loaded,
   output logic [31:0] err_addr
);

   typedef enum logic [2:0] {
      ST_SKIP, ST_LOAD, ST_DRAIN, ST_VERIFY, ST_CMP, ST_DONE, ST_FAIL
   } state_t;

   state_t      state, state_next;
   logic [31:0] skip_cnt;
   logic [31:0] loaded;
   logic [31:0] wsum, vsum;
   logic [31:0] vidx;
   logic [31:0] err_q, err_next;

   // Readback of the previous cycle's write.
   logic        chk_pend;
   logic [31:0] chk_addr;
   logic [7:0]  chk_data;

   logic        xfer;
   logic        check_fail;
   logic        unused_rd;

   assign in_ready       = !reset && (state == ST_SKIP || state == ST_LOAD || state == ST_DRAIN);
   assign xfer           = in_valid && in_ready;
   assign mem_we         = !reset && (state == ST_LOAD) && in_valid;
   assign mem_wd         = (state == ST_LOAD) ? {24'h0, in_byte} : 32'h0;
   assign mem_write_size = 2'b00;
   assign mem_addr       = (state == ST_VERIFY) ? START_ADDR + vidx : START_ADDR + loaded;
   assign mem_ro_addr2   = chk_addr;
   assign check_fail     = chk_pend && (mem_rd2[7:0] != chk_data);

   assign done           = (state == ST_DONE);
   assign error          = (state == ST_FAIL);
   assign loader_or_cpu  = (state == ST_DONE);
   assign bytes_loaded   = loaded;
   assign err_addr       = err_q;

   // Only the low byte of each read port carries loaded data.
   assign unused_rd      = ^{mem_rd[31:8], mem_rd2[31:8]};

   always_comb begin
      // NOTE: every output of this block gets a default first so that no
      // path leaves it unassigned, which would otherwise infer a latch.
      state_next = state;
      err_next   = err_q;

      unique case (state)
         ST_SKIP: begin
            if (xfer) begin
               if (in_last)                            state_next = ST_CMP;
               else if (skip_cnt == FILE_OFFSET - 1)   state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               if (in_last)                            state_next = ST_VERIFY;
               else if (loaded + 32'd1 == MEM_SIZE)    state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Reaching DRAIN implies bytes_loaded == MEM_SIZE > 0.
            if (xfer && in_last)                       state_next = ST_VERIFY;
         end
         ST_VERIFY: begin
            if (vidx == loaded - 32'd1)                state_next = ST_CMP;
         end
         ST_CMP: begin
            if (vsum == wsum) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_FAIL;
               err_next   = START_ADDR;
            end
         end
         default: ;  // DONE and FAIL hold until reset
      endcase

      // A failed readback overrides whatever else this cycle decided.
      if (check_fail && state != ST_FAIL) begin
         state_next = ST_FAIL;
         err_next   = chk_addr;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_SKIP;
         skip_cnt <= '0;
         loaded   <= '0;
         wsum     <= '0;
         vsum     <= '0;
         vidx     <= '0;
         err_q    <= '0;
         chk_pend <= 1'b0;
         chk_addr <= '0;
         chk_data <= '0;
      end else begin
         state    <= state_next;
         err_q    <= err_next;
         chk_pend <= mem_we;
         if (mem_we) begin
            chk_addr <= mem_addr;
            chk_data <= in_byte;
         end
         if (xfer && state == ST_SKIP) skip_cnt <= skip_cnt + 32'd1;
         if (xfer && state == ST_LOAD) begin
            loaded <= loaded + 32'd1;
            wsum   <= wsum + {24'h0, in_byte};
         end
         if (state == ST_VERIFY) begin
            vsum <= vsum + {24'h0, mem_rd[7:0]};
            vidx <= vidx + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//   Self-checking bench for program_loader. It supplies a byte-wide target
//   memory with two combinational read ports, streams files with random
//   filler/payload bytes and optional idle gaps, and keeps a stream-level
//   model (bytes accepted, bytes stored, stored payload) that every cycle's
//   outputs are compared against. Completion latency, final status and
//   memory contents are checked after each file.
// ---------------------------------------------------------------------------
module tb_program_loader;

   localparam int          MEM_SIZE = 8192;
   localparam logic [31:0] START    = 32'h8000_0000;
   localparam int          OFFSET   = 32'h1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_last, in_ready;
   logic [7:0]  in_byte;
   logic [31:0] mem_addr, mem_ro_addr2, mem_wd, mem_rd, mem_rd2;
   logic [31:0] bytes_loaded, err_addr;
   logic        mem_we, loader_or_cpu, done, error;
   logic [1:0]  mem_write_size;

   always #5 clk = ~clk;

   program_loader #(
      .MEM_SIZE   (MEM_SIZE),
      .START_ADDR (START),
      .FILE_OFFSET(OFFSET)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_byte       (in_byte),
      .in_last       (in_last),
      .in_ready      (in_ready),
      .mem_addr      (mem_addr),
      .mem_ro_addr2  (mem_ro_addr2),
      .mem_we        (mem_we),
      .mem_write_size(mem_write_size),
      .mem_wd        (mem_wd),
      .mem_rd        (mem_rd),
      .mem_rd2       (mem_rd2),
      .loader_or_cpu (loader_or_cpu),
      .done          (done),
      .error         (error),
      .bytes_loaded  (bytes_loaded),
      .err_addr      (err_addr)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- target memory ----------------
   logic [7:0]  ram [MEM_SIZE];
   logic [31:0] wr_off;
   int          corrupt_mode = 0;  // 0 none, 1 corrupt write to byte 2, 2 flip byte 0 later
   int          n_writes = 0;
   logic [31:0] last_we_addr = '0;

   function automatic logic [31:0] ram_read(input logic [31:0] a);
      logic [31:0] o;
      o = a - START;
      if (o < MEM_SIZE) return {24'h0, ram[o[12:0]]};
      return 32'h0;
   endfunction

   always_comb begin
      mem_rd  = ram_read(mem_addr);
      mem_rd2 = ram_read(mem_ro_addr2);
   end

   assign wr_off = mem_addr - START;

   always @(posedge clk) begin
      if (mem_we) begin
         if (wr_off < MEM_SIZE) begin
            if (corrupt_mode == 1 && wr_off == 2) ram[wr_off[12:0]] <= mem_wd[7:0] ^ 8'hA5;
            else                                  ram[wr_off[12:0]] <= mem_wd[7:0];
            if (corrupt_mode == 2 && wr_off == 4) ram[0] <= ram[0] ^ 8'h01;
         end
         n_writes     <= n_writes + 1;
         last_we_addr <= mem_addr;
      end
   end

   // ---------------- stream-level model ----------------
   int         m_acc = 0;      // bytes accepted since reset
   int         m_loaded = 0;   // bytes that must have been stored
   bit         m_stream = 1'b0; // file still being accepted
   logic [7:0] m_pay [MEM_SIZE];

   always @(posedge clk) begin
      if (reset) begin
         m_acc    <= 0;
         m_loaded <= 0;
         m_stream <= 1'b1;
      end else if (m_stream && in_valid) begin
         m_acc <= m_acc + 1;
         if (m_acc >= OFFSET && m_loaded < MEM_SIZE) begin
            m_pay[m_loaded] <= in_byte;
            m_loaded        <= m_loaded + 1;
         end
         if (in_last) m_stream <= 1'b0;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("write_size", {30'h0, mem_write_size}, 32'h0);
         if (reset) begin
            check("rst_in_ready", {31'h0, in_ready}, 32'h0);
            check("rst_mem_we",   {31'h0, mem_we},   32'h0);
         end else if (m_stream) begin
            logic exp_we;
            exp_we = in_valid && (m_acc >= OFFSET) && (m_loaded < MEM_SIZE);
            check("in_ready",     {31'h0, in_ready}, 32'h1);
            check("mem_we",       {31'h0, mem_we},   {31'h0, exp_we});
            check("mem_addr",     mem_addr,          START + m_loaded);
            check("bytes_loaded", bytes_loaded,      m_loaded);
            if (exp_we) check("mem_wd", mem_wd, {24'h0, in_byte});
         end else begin
            check("post_in_ready", {31'h0, in_ready}, 32'h0);
            check("post_mem_we",   {31'h0, mem_we},   32'h0);
            check("post_mem_wd",   mem_wd,            32'h0);
            check("post_loaded",   bytes_loaded,      m_loaded);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] file_q [$];

   task automatic build_file(input int n_fill, input int n_pay);
      file_q.delete();
      for (int i = 0; i < n_fill + n_pay; i++) file_q.push_back(8'($urandom));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // gap: 0 back-to-back, 1 idle cycle between bytes, 2 random idle cycles
   task automatic send_file(input int n_send, input int gap);
      for (int i = 0; i < n_send; i++) begin
         if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(3) == 0)) begin
            in_valid = 1'b0; in_last = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_byte  = file_q[i];
         in_last  = (i == file_q.size() - 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h0;
   endtask

   // Called one step after the in_last transfer edge; status must appear in
   // exactly the n-th cycle after that edge.
   task automatic expect_finish(input int n, input bit want_done, input logic [31:0] want_err,
                                input string tag);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (k < n) begin
            check({tag, "_early"}, {31'h0, done | error}, 32'h0);
         end else begin
            check({tag, "_done"},  {31'h0, done},          {31'h0, want_done});
            check({tag, "_error"}, {31'h0, error},         {31'h0, !want_done});
            check({tag, "_owner"}, {31'h0, loader_or_cpu}, {31'h0, want_done});
            if (!want_done) check({tag, "_err_addr"}, err_addr, want_err);
         end
      end
      @(posedge clk); #1;
   endtask

   function automatic int finish_latency();
      return (m_loaded == 0) ? 2 : m_loaded + 2;
   endfunction

   task automatic check_mem(input string tag);
      int mism = 0;
      for (int i = 0; i < m_loaded; i++) if (ram[i] !== m_pay[i]) mism++;
      check(tag, mism, 0);
   endtask

   task automatic random_run(input string tag);
      build_file(OFFSET, int'($urandom_range(64, 1)));
      do_reset();
      send_file(file_q.size(), 2);
      expect_finish(finish_latency(), 1'b1, 32'h0, tag);
      check_mem({tag, "_mem"});
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int w0, k;
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h0;
      do_reset();
      chk_en = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_done",     {31'h0, done},          32'h0);
      check("rst_error",    {31'h0, error},         32'h0);
      check("rst_owner",    {31'h0, loader_or_cpu}, 32'h0);
      check("rst_loaded",   bytes_loaded,           32'h0);
      check("rst_err_addr", err_addr,               32'h0);
      check("rst_ready",    {31'h0, in_ready},      32'h1);
      @(posedge clk); #1;

      // Four-byte payload behind a 0x1000-byte header
      build_file(OFFSET, 4);
      file_q[OFFSET] = 8'h13; file_q[OFFSET+1] = 8'h05;
      file_q[OFFSET+2] = 8'h00; file_q[OFFSET+3] = 8'h00;
      send_file(file_q.size(), 0);
      expect_finish(6, 1'b1, 32'h0, "small");
      check("small_loaded", bytes_loaded, 32'd4);
      check("small_m0", {24'h0, ram[0]}, 32'h13);
      check("small_m1", {24'h0, ram[1]}, 32'h05);
      check("small_m2", {24'h0, ram[2]}, 32'h00);
      check("small_m3", {24'h0, ram[3]}, 32'h00);

      random_run("rand_a");

      // Same small file with an idle cycle between every byte
      build_file(OFFSET, 4);
      file_q[OFFSET] = 8'h13; file_q[OFFSET+1] = 8'h05;
      file_q[OFFSET+2] = 8'h00; file_q[OFFSET+3] = 8'h00;
      do_reset();
      send_file(file_q.size(), 1);
      expect_finish(6, 1'b1, 32'h0, "gapped");
      check("gapped_loaded", bytes_loaded, 32'd4);
      check("gapped_m0", {24'h0, ram[0]}, 32'h13);
      check("gapped_m1", {24'h0, ram[1]}, 32'h05);
      check("gapped_m2", {24'h0, ram[2]}, 32'h00);
      check("gapped_m3", {24'h0, ram[3]}, 32'h00);

      // Memory stores a wrong byte at 0x80000002
      build_file(OFFSET, 4);
      chk_en = 1'b0;
      do_reset();
      corrupt_mode = 1;
      send_file(file_q.size(), 0);
      k = 0;
      while (!(error || done) && k < 20000) begin @(negedge clk); k++; end
      check("wcorrupt_timeout", {31'h0, k >= 20000}, 32'h0);
      @(negedge clk);
      check("wcorrupt_error",    {31'h0, error},         32'h1);
      check("wcorrupt_done",     {31'h0, done},          32'h0);
      check("wcorrupt_owner",    {31'h0, loader_or_cpu}, 32'h0);
      check("wcorrupt_err_addr", err_addr,               32'h8000_0002);
      corrupt_mode = 0;
      do_reset();
      chk_en = 1'b1;

      // Byte 0 changes after its readback: only the checksum can catch it
      build_file(OFFSET, 8);
      corrupt_mode = 2;
      send_file(file_q.size(), 0);
      expect_finish(10, 1'b0, START, "sumfail");
      corrupt_mode = 0;

      // Reset after ten payload bytes, then stream the whole file again
      build_file(OFFSET, 20);
      do_reset();
      send_file(OFFSET + 10, 0);
      check("midrst_before", bytes_loaded, 32'd10);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_loaded", bytes_loaded,      32'h0);
      check("midrst_ready",  {31'h0, in_ready}, 32'h1);
      check("midrst_addr",   mem_addr,          START);
      check("midrst_done",   {31'h0, done},     32'h0);
      @(posedge clk); #1;
      send_file(file_q.size(), 0);
      expect_finish(finish_latency(), 1'b1, 32'h0, "midrst");
      check("midrst_final", bytes_loaded, 32'd20);
      check_mem("midrst_mem");

      // File ends inside the discarded header
      build_file(32'h800, 0);
      do_reset();
      w0 = n_writes;
      send_file(file_q.size(), 0);
      expect_finish(2, 1'b1, 32'h0, "header_only");
      check("header_loaded", bytes_loaded, 32'h0);
      check("header_writes", n_writes - w0, 0);

      random_run("rand_b");

      // Payload larger than memory: 8 surplus bytes drained
      build_file(OFFSET, 8200);
      do_reset();
      w0 = n_writes;
      send_file(file_q.size(), 0);
      expect_finish(finish_latency(), 1'b1, 32'h0, "overflow");
      check("overflow_loaded", bytes_loaded, 32'd8192);
      check("overflow_writes", n_writes - w0, 8192);
      check("overflow_last",   last_we_addr, 32'h8000_1FFF);
      check("overflow_top",    {24'h0, ram[8191]}, {24'h0, file_q[OFFSET + 8191]});
      check_mem("overflow_mem");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #(98000 * 10);
      $display("FAIL watchdog: simulation did not finish within the cycle budget");
      $fatal(1, "watchdog");
   end

endmodule
